// File: rtl/ex_div_unit_if.sv
// Handshake and operand bus between the EX stage and the iterative divider.
// The master is the pipeline side and the slave is the divider.
interface ex_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, opA, opB, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, opA, opB, flush,
        output busy, done, result
    );
endinterface

// File: rtl/ex_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider on magnitudes with a sign-fix cycle.
//
// state | meaning
// IDLE  | waiting for start; divide-by-zero and overflow results are produced from here
// ITER  | one restoring quotient step per cycle, XLEN cycles
// FIX   | apply operand signs, load result, pulse done
module ex_div_unit #(
    parameter int XLEN = 32
) (
    input logic          CLK,
    input logic          RST,
    ex_div_unit_if.slave div_if
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] count;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] divisor_q;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic            spec_pend;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] result_q;
    logic            done_q;

    logic            accept;
    logic            is_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        accept      = div_if.start && div_if.funct3[2] && !div_if.flush && (state == IDLE);
        is_signed   = ~div_if.funct3[0];
        sign_a      = is_signed & div_if.opA[XLEN-1];
        sign_b      = is_signed & div_if.opB[XLEN-1];
        abs_a       = sign_a ? (~div_if.opA + 1'b1) : div_if.opA;
        abs_b       = sign_b ? (~div_if.opB + 1'b1) : div_if.opB;
        div_zero    = (div_if.opB == '0);
        sgn_ovf     = is_signed && (div_if.opA == MIN_NEG) && (div_if.opB == '1);
        if (div_zero)
            special_res = div_if.funct3[1] ? div_if.opA : '1;
        else
            special_res = div_if.funct3[1] ? '0 : MIN_NEG;

        // Partial remainder stays below the divisor, so its low XLEN bits plus the next dividend bit suffice.
        shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        trial   = shifted - {1'b0, divisor_q};

        q_fix = neg_q ? (~quo_q + 1'b1) : quo_q;
        r_fix = neg_r ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            is_rem    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            spec_pend <= 1'b0;
            spec_res  <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            spec_pend <= 1'b0;
            // A pending special result retires even if a new op is accepted at this edge.
            if (spec_pend) begin
                result_q <= spec_res;
                done_q   <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem <= div_if.funct3[1];
                        neg_q  <= sign_a ^ sign_b;
                        neg_r  <= sign_a;
                        if (div_zero || sgn_ovf) begin
                            spec_res  <= special_res;
                            spec_pend <= 1'b1;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= abs_a;
                            divisor_q <= abs_b;
                            count     <= '0;
                            state     <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (div_if.flush) begin
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        if (!trial[XLEN]) begin
                            rem_q <= trial;
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= shifted;
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                        if (count == CNT_W'(XLEN-1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (!div_if.flush) begin
                        result_q <= is_rem ? r_fix : q_fix;
                        done_q   <= 1'b1;
                    end
                    count <= '0;
                    state <= IDLE;
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign div_if.busy   = (state != IDLE);
    assign div_if.done   = done_q;
    assign div_if.result = result_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: latency, special cases, flush, reset and back-to-back handling.
module tb_ex_div_unit;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    ex_div_unit_if #(.XLEN(32)) div_if ();

    ex_div_unit #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .div_if (div_if)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (!f3[0]) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    task automatic drive_idle();
        div_if.start  = 1'b0;
        div_if.funct3 = 3'b000;
        div_if.opA    = 32'h0;
        div_if.opB    = 32'h0;
        div_if.flush  = 1'b0;
    endtask

    // Issues one op and observes a bounded window at negedges; k=0 is the cycle after the accepting edge.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_n, output int done_n);
        @(negedge CLK);
        div_if.start  = 1'b1;
        div_if.funct3 = f3;
        div_if.opA    = a;
        div_if.opB    = b;
        @(negedge CLK);
        div_if.start = 1'b0;
        lat    = -1;
        busy_n = 0;
        done_n = 0;
        res    = 32'h0;
        for (int k = 0; k < 40; k++) begin
            if (div_if.busy) busy_n++;
            if (div_if.done) begin
                done_n++;
                if (lat < 0) begin
                    lat = k;
                    res = div_if.result;
                end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        RST = 1'b1;
        div_if.start  = 1'b1;
        div_if.funct3 = F_DIVU;
        div_if.opA    = 32'd100;
        div_if.opB    = 32'd7;
        repeat (3) @(negedge CLK);
        checks++;
        if (div_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", div_if.busy); end
        checks++;
        if (div_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", div_if.done); end
        checks++;
        if (div_if.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", div_if.result); end
        drive_idle();
        RST = 1'b0;
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        logic [31:0] res;
        int lat, busy_n, done_n;
        vecs.push_back('{F_DIVU, 32'd100,        32'd7,        32'h0000_000E, 33});
        vecs.push_back('{F_REMU, 32'd100,        32'd7,        32'h0000_0002, 33});
        vecs.push_back('{F_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33});
        vecs.push_back('{F_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33});
        vecs.push_back('{F_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 33});
        vecs.push_back('{F_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33});
        vecs.push_back('{F_DIVU, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33});
        vecs.push_back('{F_REMU, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 33});
        vecs.push_back('{F_DIV,  32'h8000_0000, 32'd2,        32'hC000_0000, 33});
        vecs.push_back('{F_REM,  32'h8000_0000, 32'd3,        32'hFFFF_FFFE, 33});
        vecs.push_back('{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{F_DIV,  32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        vecs.push_back('{F_DIV,  32'h1234_5678, 32'h0,        32'hFFFF_FFFF, 1});
        vecs.push_back('{F_REMU, 32'h1234_5678, 32'h0,        32'h1234_5678, 1});
        vecs.push_back('{F_REM,  32'h0,         32'h0,        32'h0000_0000, 1});
        vecs.push_back('{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        foreach (vecs[i]) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, busy_n, done_n);
            checks++;
            if (res !== vecs[i].exp) begin
                errors++;
                $display("FAIL directed[%0d]_result got %h want %h", i, res, vecs[i].exp);
            end
            checks++;
            if (lat != vecs[i].lat) begin
                errors++;
                $display("FAIL directed[%0d]_latency got %0d want %0d", i, lat, vecs[i].lat);
            end
            checks++;
            if (done_n != 1) begin
                errors++;
                $display("FAIL directed[%0d]_done_count got %0d want 1", i, done_n);
            end
            checks++;
            if (busy_n != ((vecs[i].lat == 1) ? 0 : 33)) begin
                errors++;
                $display("FAIL directed[%0d]_busy_cycles got %0d want %0d", i, busy_n, (vecs[i].lat == 1) ? 0 : 33);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] res;
        int lat, busy_n, done_n;
        do_op(F_DIVU, 32'd100, 32'd7, res, lat, busy_n, done_n);
        do_op(3'b000, 32'd50, 32'd5, res, lat, busy_n, done_n);
        checks++;
        if (busy_n != 0 || done_n != 0) begin
            errors++;
            $display("FAIL ignore_mul_funct3 got busy=%0d done=%0d want 0 0", busy_n, done_n);
        end
        div_if.flush = 1'b1;
        do_op(F_DIVU, 32'd50, 32'd5, res, lat, busy_n, done_n);
        div_if.flush = 1'b0;
        checks++;
        if (busy_n != 0 || done_n != 0) begin
            errors++;
            $display("FAIL ignore_start_with_flush got busy=%0d done=%0d want 0 0", busy_n, done_n);
        end
        checks++;
        if (div_if.result !== 32'h0000_000E) begin
            errors++;
            $display("FAIL ignore_result_held got %h want 0000000e", div_if.result);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, busy_n, done_n;
        do_op(F_DIVU, 32'd100, 32'd7, res, lat, busy_n, done_n);
        @(negedge CLK);
        div_if.start  = 1'b1;
        div_if.funct3 = F_DIVU;
        div_if.opA    = 32'd1000;
        div_if.opB    = 32'd10;
        @(negedge CLK);
        div_if.start = 1'b0;
        repeat (10) @(negedge CLK);
        div_if.flush = 1'b1;
        @(negedge CLK);
        div_if.flush = 1'b0;
        checks++;
        if (div_if.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", div_if.busy); end
        checks++;
        if (div_if.done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", div_if.done); end
        checks++;
        if (div_if.result !== 32'h0000_000E) begin errors++; $display("FAIL flush_result_held got %h want 0000000e", div_if.result); end
        do_op(F_DIVU, 32'd1000, 32'd10, res, lat, busy_n, done_n);
        checks++;
        if (res !== 32'd100 || lat != 33 || done_n != 1) begin
            errors++;
            $display("FAIL flush_restart got res=%h lat=%0d done=%0d want 00000064 33 1", res, lat, done_n);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int done_n;
        logic [31:0] res;
        @(negedge CLK);
        div_if.start  = 1'b1;
        div_if.funct3 = F_DIV;
        div_if.opA    = 32'hFFFF_FFF9;
        div_if.opB    = 32'd2;
        @(negedge CLK);
        div_if.start = 1'b0;
        repeat (20) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (div_if.busy !== 1'b0 || div_if.done !== 1'b0 || div_if.result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got busy=%b done=%b res=%h want 0 0 00000000", div_if.busy, div_if.done, div_if.result);
        end
        RST = 1'b0;
        div_if.start  = 1'b1;
        div_if.funct3 = F_REM;
        div_if.opA    = 32'hFFFF_FFF9;
        div_if.opB    = 32'd2;
        @(negedge CLK);
        div_if.start = 1'b0;
        lat = -1;
        done_n = 0;
        res = 32'h0;
        for (int k = 0; k < 40; k++) begin
            if (div_if.done) begin
                done_n++;
                if (lat < 0) begin lat = k; res = div_if.result; end
            end
            @(negedge CLK);
        end
        checks++;
        if (res !== 32'hFFFF_FFFF || lat != 33 || done_n != 1) begin
            errors++;
            $display("FAIL reset_first_start got res=%h lat=%0d done=%0d want ffffffff 33 1", res, lat, done_n);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        int done_n;
        logic [31:0] res;
        @(negedge CLK);
        div_if.start  = 1'b1;
        div_if.funct3 = F_DIVU;
        div_if.opA    = 32'd100;
        div_if.opB    = 32'd7;
        @(negedge CLK);
        div_if.start = 1'b0;
        lat = -1;
        done_n = 0;
        res = 32'h0;
        for (int k = 0; k < 40; k++) begin
            div_if.start = (k == 5);
            if (k == 5) begin
                div_if.funct3 = F_DIVU;
                div_if.opA    = 32'd1000;
                div_if.opB    = 32'd10;
            end
            if (div_if.done) begin
                done_n++;
                if (lat < 0) begin lat = k; res = div_if.result; end
            end
            @(negedge CLK);
        end
        div_if.start = 1'b0;
        checks++;
        if (res !== 32'h0000_000E || lat != 33 || done_n != 1) begin
            errors++;
            $display("FAIL start_while_busy got res=%h lat=%0d done=%0d want 0000000e 33 1", res, lat, done_n);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int done_n;
        int k;
        logic [31:0] res;
        @(negedge CLK);
        div_if.start  = 1'b1;
        div_if.funct3 = F_REMU;
        div_if.opA    = 32'd100;
        div_if.opB    = 32'd7;
        @(negedge CLK);
        div_if.start = 1'b0;
        k = 0;
        while (!div_if.done && k < 40) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (k != 33 || div_if.result !== 32'h0000_0002) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d res=%h want 33 00000002", k, div_if.result);
        end
        div_if.start  = 1'b1;
        div_if.funct3 = F_DIV;
        div_if.opA    = 32'hFFFF_FFF9;
        div_if.opB    = 32'hFFFF_FFFE;
        @(negedge CLK);
        div_if.start = 1'b0;
        lat = -1;
        done_n = 0;
        res = 32'h0;
        for (int j = 0; j < 40; j++) begin
            if (div_if.done) begin
                done_n++;
                if (lat < 0) begin lat = j; res = div_if.result; end
            end
            @(negedge CLK);
        end
        checks++;
        if (res !== 32'h0000_0003 || lat != 33 || done_n != 1) begin
            errors++;
            $display("FAIL b2b_second got res=%h lat=%0d done=%0d want 00000003 33 1", res, lat, done_n);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] corners [5];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [2:0]  f3;
        logic [31:0] res;
        int lat, busy_n, done_n;
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 150; i++) begin
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 3))
                0:       b = corners[$urandom_range(0, 4)];
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            exp = ref_model(f3, a, b);
            do_op(f3, a, b, res, lat, busy_n, done_n);
            checks++;
            if (res !== exp || done_n != 1) begin
                errors++;
                $display("FAIL sweep[%0d] f3=%b a=%h b=%h got %h done=%0d want %h 1", i, f3, a, b, res, done_n, exp);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        drive_idle();
        test_reset();
        test_directed();
        test_ignored_start();
        test_flush();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
